operand2_stage: RTL and testbench

Registered operand-2 stage of the CPU datapath, sitting between register read and the ALU. It decodes the operand-2 field of a data-processing instruction and produces the second ALU operand plus the shifter carry-out. It covers three forms: rotated 8-bit immediate, immediate-amount shift of Rm, and register-amount shift of Rm. A register-amount shift needs a second register-file read of Rs, so it takes an extra cycle behind a valid/ready handshake.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/operand2_shift_core.sv | 78 +++++++
 rtl/operand2_stage.sv | 183 ++++++++++++++++++
 tb/tb_operand2_stage.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared datapath types: shift-type and operand-2 FSM encodings, instruction bit positions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Instruction bit positions used by the operand-2 decode
  localparam int I_BIT         = 25;
  localparam int REG_SHIFT_BIT = 4;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RS_FETCH = 2'b01,
    OUT      = 2'b10
  } state_t;

endpackage

// File: rtl/operand2_shift_core.sv
// Barrel shifter/rotator for operand 2, including all amount-0 and amount>=32 special cases.
// Latency: purely combinational.
// Backpressure: none; the enclosing stage registers around it.
module operand2_shift_core
  import cpu_pkg::*;
(
  input  logic [31:0] i_value,
  input  logic [1:0]  i_type,
  input  logic [7:0]  i_amount,
  input  logic        i_reg_mode,  // 1: amount from Rs[7:0] (also used for rotated immediates)
  input  logic        i_c_in,
  output logic [31:0] o_result,
  output logic        o_carry
);

  logic [4:0]  w_sh;
  logic        w_big;
  logic        w_eq32;
  logic [31:0] w_lsl;
  logic [31:0] w_lsr;
  logic [31:0] w_asr;
  logic [31:0] w_ror;
  logic        w_c_left;
  logic        w_c_right;

  assign w_sh   = i_amount[4:0];
  assign w_big  = |i_amount[7:5];
  assign w_eq32 = (i_amount == 8'd32);

  // Plain shifts for amounts 1..31; the carry is the last bit pushed out
  assign w_lsl     = i_value << w_sh;
  assign w_lsr     = i_value >> w_sh;
  assign w_asr     = $signed(i_value) >>> w_sh;
  assign w_ror     = (i_value >> w_sh) | (i_value << (5'd0 - w_sh));
  assign w_c_left  = i_value[5'd0 - w_sh];
  assign w_c_right = i_value[w_sh - 5'd1];

  // Select result and carry, applying the amount-0 and >=32 encodings first
  always_comb begin
    o_result = i_value;
    o_carry  = i_c_in;
    if (i_amount == 8'd0) begin
      // Register mode: shift by zero passes Rm and C. Immediate mode reuses #0 encodings.
      if (!i_reg_mode) begin
        case (shift_t'(i_type))
          LSR: begin o_result = 32'd0;               o_carry = i_value[31]; end
          ASR: begin o_result = {32{i_value[31]}};   o_carry = i_value[31]; end
          ROR: begin o_result = {i_c_in, i_value[31:1]}; o_carry = i_value[0]; end
          default: ;
        endcase
      end
    end else if (w_big) begin
      case (shift_t'(i_type))
        LSL: begin o_result = 32'd0; o_carry = w_eq32 ? i_value[0]  : 1'b0; end
        LSR: begin o_result = 32'd0; o_carry = w_eq32 ? i_value[31] : 1'b0; end
        ASR: begin o_result = {32{i_value[31]}}; o_carry = i_value[31]; end
        default: begin
          // Rotation only cares about amount mod 32
          if (w_sh == 5'd0) begin
            o_result = i_value;
            o_carry  = i_value[31];
          end else begin
            o_result = w_ror;
            o_carry  = w_ror[31];
          end
        end
      endcase
    end else begin
      case (shift_t'(i_type))
        LSL:     begin o_result = w_lsl; o_carry = w_c_left;  end
        LSR:     begin o_result = w_lsr; o_carry = w_c_right; end
        ASR:     begin o_result = w_asr; o_carry = w_c_right; end
        default: begin o_result = w_ror; o_carry = w_ror[31]; end
      endcase
    end
  end

endmodule

// File: rtl/operand2_stage.sv
// Registered operand-2 stage: decodes immediate / imm-shift / reg-shift forms into op2 + carry.
// Latency: 1 cycle accept->out_valid, 2 cycles for register-amount shifts (extra Rs read).
// Backpressure: in_ready drops while a result is held unconsumed or an Rs read is in flight.
// Optional feature macro: OPERAND2_REG_SHIFT_EN (register-amount shifts; otherwise flagged unsupported).
module operand2_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rm_data,
  input  logic              c_flag,
  output logic              rs_rd_en,
  output logic [3:0]        rs_addr,
  input  logic [DATA_W-1:0] rs_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] op2,
  output logic              shifter_carry,
  output logic              out_unsupported
);

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic        w_is_imm;
  logic        w_is_reg;
  logic        w_load;
  logic [31:0] w_val;
  logic [1:0]  w_type;
  logic [7:0]  w_amt;
  logic        w_mode;
  logic        w_cin;
  logic [31:0] w_core_result;
  logic        w_core_carry;
  logic [31:0] w_res;
  logic        w_car;
  logic        w_uns;
  logic [31:0] r_op2;
  logic        r_carry;
  logic        r_unsup;
  logic        w_unused_bits;

`ifdef OPERAND2_REG_SHIFT_EN
  logic        w_capture;
  logic [31:0] r_rm;
  logic [1:0]  r_type;
  logic        r_c;
`endif

  assign in_ready  = rst_n && ((r_state == IDLE) || ((r_state == OUT) && out_ready));
  assign w_accept  = in_valid && in_ready;
  assign w_is_imm  = instr[I_BIT];
  assign w_is_reg  = !w_is_imm && instr[REG_SHIFT_BIT];
  assign rs_addr   = instr[11:8];
  assign out_valid = (r_state == OUT);
  assign op2             = r_op2;
  assign shifter_carry   = r_carry;
  assign out_unsupported = r_unsup;

  // Opcode/register fields outside operand 2 are not needed here
  assign w_unused_bits = ^{instr[31:26], instr[24:12], rs_data};

`ifdef OPERAND2_REG_SHIFT_EN
  assign rs_rd_en = w_accept && w_is_reg;
`else
  assign rs_rd_en = 1'b0;
`endif

  // Steer the shifter: live instruction fields, or captured Rm/type/C while Rs arrives
  always_comb begin
    w_val  = rm_data;
    w_type = instr[6:5];
    w_amt  = {3'b000, instr[11:7]};
    w_mode = 1'b0;
    w_cin  = c_flag;
    if (w_is_imm) begin
      // Rotated immediate is a register-mode ROR by 2*rot: rot=0 keeps C, else carry=op2[31]
      w_val  = {24'd0, instr[7:0]};
      w_type = ROR;
      w_amt  = {3'b000, instr[11:8], 1'b0};
      w_mode = 1'b1;
    end
`ifdef OPERAND2_REG_SHIFT_EN
    if (r_state == RS_FETCH) begin
      w_val  = r_rm;
      w_type = r_type;
      w_amt  = rs_data[7:0];
      w_mode = 1'b1;
      w_cin  = r_c;
    end
`endif
  end

  operand2_shift_core u_core (
    .i_value    (w_val),
    .i_type     (w_type),
    .i_amount   (w_amt),
    .i_reg_mode (w_mode),
    .i_c_in     (w_cin),
    .o_result   (w_core_result),
    .o_carry    (w_core_carry)
  );

  // Next-state and result-load decisions
  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_res  = w_core_result;
    w_car  = w_core_carry;
    w_uns  = 1'b0;
`ifdef OPERAND2_REG_SHIFT_EN
    w_capture = 1'b0;
`endif
    case (r_state)
`ifdef OPERAND2_REG_SHIFT_EN
      RS_FETCH: begin
        w_load = 1'b1;
        w_next = OUT;
      end
`endif
      default: begin
        if (w_accept) begin
          if (w_is_reg) begin
`ifdef OPERAND2_REG_SHIFT_EN
            w_capture = 1'b1;
            w_next    = RS_FETCH;
`else
            // Without register shifts, pass Rm/C through and flag it
            w_load = 1'b1;
            w_next = OUT;
            w_res  = rm_data;
            w_car  = c_flag;
            w_uns  = 1'b1;
`endif
          end else begin
            w_load = 1'b1;
            w_next = OUT;
          end
        end else if ((r_state == OUT) && out_ready) begin
          w_next = IDLE;
        end
      end
    endcase
  end

  // State and output registers; reset drops any pending operation
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_op2   <= 32'd0;
      r_carry <= 1'b0;
      r_unsup <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_op2   <= w_res;
        r_carry <= w_car;
        r_unsup <= w_uns;
      end
    end
  end

`ifdef OPERAND2_REG_SHIFT_EN
  // Hold Rm, shift type and C across the Rs read cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rm   <= 32'd0;
      r_type <= 2'b00;
      r_c    <= 1'b0;
    end else if (w_capture) begin
      r_rm   <= rm_data;
      r_type <= instr[6:5];
      r_c    <= c_flag;
    end
  end
`endif

endmodule

// File: tb/tb_operand2_stage.sv
// Directed, table-driven bench for operand2_stage with hand-computed expectations.
// Latency: checks 1-cycle and 2-cycle accept-to-valid paths.
// Backpressure: exercises held outputs and same-cycle transfer+accept.
module tb_operand2_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rm_data;
  logic        c_flag;
  logic        rs_rd_en;
  logic [3:0]  rs_addr;
  logic [31:0] rs_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] op2;
  logic        shifter_carry;
  logic        out_unsupported;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rm;
    logic        c;
    logic [31:0] op2;
    logic        carry;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rm;
    logic        c;
    logic [31:0] rs;
    logic [31:0] op2;
    logic        carry;
  } rvec_t;

  vec_t  vecs  [13];
  rvec_t rvecs [10];

  always #5 clk = ~clk;

  operand2_stage #(.DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .instr           (instr),
    .rm_data         (rm_data),
    .c_flag          (c_flag),
    .rs_rd_en        (rs_rd_en),
    .rs_addr         (rs_addr),
    .rs_data         (rs_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .op2             (op2),
    .shifter_carry   (shifter_carry),
    .out_unsupported (out_unsupported)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    instr = v.instr; rm_data = v.rm; c_flag = v.c; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    check({tag, ".rs_rd_en"}, 32'(rs_rd_en), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".op2"}, op2, v.op2);
    check({tag, ".carry"}, 32'(shifter_carry), 32'(v.carry));
    check({tag, ".unsup"}, 32'(out_unsupported), 32'd0);
    tick();
    check({tag, ".drain"}, 32'(out_valid), 32'd0);
  endtask

  task automatic run_reg(input int idx, input rvec_t v);
    string tag;
    tag = $sformatf("rvec%0d", idx);
    instr = v.instr; rm_data = v.rm; c_flag = v.c; in_valid = 1'b1; out_ready = 1'b1;
    rs_data = 32'hFFFF_FFFF;
    #1;
`ifdef OPERAND2_REG_SHIFT_EN
    check({tag, ".rs_rd_en"}, 32'(rs_rd_en), 32'd1);
    check({tag, ".rs_addr"}, 32'(rs_addr), 32'(v.instr[11:8]));
    tick();
    // Change live inputs so only captured values can give the right answer
    in_valid = 1'b0; rs_data = v.rs; rm_data = ~v.rm; c_flag = ~v.c; instr = 32'h0000_0000;
    #1;
    check({tag, ".fetch_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".fetch_ready"}, 32'(in_ready), 32'd0);
    tick();
    rs_data = 32'hFFFF_FFFF;
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".op2"}, op2, v.op2);
    check({tag, ".carry"}, 32'(shifter_carry), 32'(v.carry));
    check({tag, ".unsup"}, 32'(out_unsupported), 32'd0);
`else
    check({tag, ".rs_rd_en"}, 32'(rs_rd_en), 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".op2"}, op2, v.rm);
    check({tag, ".carry"}, 32'(shifter_carry), 32'(v.c));
    check({tag, ".unsup"}, 32'(out_unsupported), 32'd1);
`endif
    tick();
    check({tag, ".drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    // Immediate and immediate-shift forms: {instr, Rm, C, op2, carry}
    vecs[0]  = '{32'h0200_04FF, 32'h0000_0000, 1'b0, 32'hFF00_0000, 1'b1}; // imm FF ror 8
    vecs[1]  = '{32'h0200_0012, 32'h0000_0000, 1'b1, 32'h0000_0012, 1'b1}; // rot 0 keeps C
    vecs[2]  = '{32'h0200_0101, 32'h0000_0000, 1'b1, 32'h4000_0000, 1'b0}; // imm 1 ror 2
    vecs[3]  = '{32'h0000_0020, 32'h8000_0FFF, 1'b0, 32'h0000_0000, 1'b1}; // LSR #0 -> 32
    vecs[4]  = '{32'h0000_0040, 32'h8000_0000, 1'b0, 32'hFFFF_FFFF, 1'b1}; // ASR #0 -> 32
    vecs[5]  = '{32'h0000_0060, 32'h0000_0003, 1'b1, 32'h8000_0001, 1'b1}; // RRX
    vecs[6]  = '{32'h0000_0000, 32'h1234_5678, 1'b0, 32'h1234_5678, 1'b0}; // LSL #0
    vecs[7]  = '{32'h0000_0200, 32'hF000_0001, 1'b0, 32'h0000_0010, 1'b1}; // LSL #4
    vecs[8]  = '{32'h0000_00A0, 32'h0000_0003, 1'b0, 32'h0000_0001, 1'b1}; // LSR #1
    vecs[9]  = '{32'h0000_0240, 32'h8000_0008, 1'b0, 32'hF800_0000, 1'b1}; // ASR #4
    vecs[10] = '{32'h0000_0460, 32'h0000_00AB, 1'b0, 32'hAB00_0000, 1'b1}; // ROR #8
    vecs[11] = '{32'h0000_0F80, 32'h0000_0003, 1'b0, 32'h8000_0000, 1'b1}; // LSL #31
    vecs[12] = '{32'h0000_0FA0, 32'h4000_0000, 1'b1, 32'h0000_0000, 1'b1}; // LSR #31

    // Register-amount shifts (Rs = r5): {instr, Rm, C, Rs, op2, carry}
    rvecs[0] = '{32'h0000_0510, 32'h0000_0001, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b1}; // LSL 32
    rvecs[1] = '{32'h0000_0510, 32'h0000_0006, 1'b1, 32'h0000_0100, 32'h0000_0006, 1'b1}; // Rs[7:0]=0
    rvecs[2] = '{32'h0000_0510, 32'h0000_0001, 1'b1, 32'h0000_0021, 32'h0000_0000, 1'b0}; // LSL 33
    rvecs[3] = '{32'h0000_0510, 32'h8000_0000, 1'b0, 32'h0000_0001, 32'h0000_0000, 1'b1}; // LSL 1
    rvecs[4] = '{32'h0000_0530, 32'h8000_0000, 1'b0, 32'h0000_0020, 32'h0000_0000, 1'b1}; // LSR 32
    rvecs[5] = '{32'h0000_0530, 32'h8000_0000, 1'b1, 32'h0000_0021, 32'h0000_0000, 1'b0}; // LSR 33
    rvecs[6] = '{32'h0000_0550, 32'h8000_0000, 1'b0, 32'h0000_0040, 32'hFFFF_FFFF, 1'b1}; // ASR 64
    rvecs[7] = '{32'h0000_0570, 32'h8000_0001, 1'b0, 32'h0000_0020, 32'h8000_0001, 1'b1}; // ROR 32
    rvecs[8] = '{32'h0000_0570, 32'h0000_000F, 1'b0, 32'h0000_0004, 32'hF000_0000, 1'b1}; // ROR 4
    rvecs[9] = '{32'h0000_0530, 32'h0000_00F8, 1'b0, 32'h0000_0004, 32'h0000_000F, 1'b1}; // LSR 4

    // Reset state, with a register-shift instruction offered during reset
    rst_n = 1'b0; in_valid = 1'b1; instr = 32'h0000_0510; rm_data = 32'h1;
    c_flag = 1'b1; rs_data = 32'h0; out_ready = 1'b1;
    tick(); tick();
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.op2", op2, 32'd0);
    check("rst.carry", 32'(shifter_carry), 32'd0);
    check("rst.unsup", 32'(out_unsupported), 32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check("rst.rs_rd_en", 32'(rs_rd_en), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    check("idle.out_valid", 32'(out_valid), 32'd0);
    check("idle.in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 13; i++) run_single(i, vecs[i]);
    for (int i = 0; i < 10; i++) run_reg(i, rvecs[i]);

    // Backpressure: hold a result for 3 cycles, then transfer with a same-cycle accept
    instr = vecs[0].instr; rm_data = vecs[0].rm; c_flag = vecs[0].c;
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d.out_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d.op2", k), op2, 32'hFF00_0000);
      check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1; in_valid = 1'b1;
    instr = vecs[3].instr; rm_data = vecs[3].rm; c_flag = vecs[3].c;
    #1;
    check("bp.accept_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    #1;
    check("bp.next_valid", 32'(out_valid), 32'd1);
    check("bp.next_op2", op2, 32'h0000_0000);
    check("bp.next_carry", 32'(shifter_carry), 32'd1);
    tick();
    check("bp.drain", 32'(out_valid), 32'd0);

    // Reset while the register-shift is mid-flight
    instr = 32'h0000_0510; rm_data = 32'h0000_0001; c_flag = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; rs_data = 32'h0000_0020; rst_n = 1'b0;
    #1;
    check("midrst.in_ready_now", 32'(in_ready), 32'd0);
    tick();
    check("midrst.out_valid", 32'(out_valid), 32'd0);
    check("midrst.in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    tick();
    check("midrst.post1_valid", 32'(out_valid), 32'd0);
    tick();
    check("midrst.post2_valid", 32'(out_valid), 32'd0);
    check("midrst.op2", op2, 32'd0);
    check("midrst.in_ready_back", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
